// File: rtl/graphics_control.sv
// Control FSM for a 64-pixel square draw with an optional white flash-and-restore
// sequence; the flash path is built only when GRAPHICS_FLASH_EN is defined.
module graphics_control #(
    parameter int unsigned HOLD_CYCLES = 12500000
) (
    input  logic clock,
    input  logic resetn,
    input  logic go,
    input  logic flash_req,
    output logic load,
    output logic enable,
    output logic flash,
    output logic ld_previous,
    output logic plot,
    output logic busy,
    output logic done
);

    typedef enum logic [3:0] {
        IDLE,
        LOAD,
        DRAW,
        FLASH_SET,
        FLASH_DRAW,
        HOLD,
        RESTORE,
        RESTORE_DRAW,
        DONE
    } state_t;

    state_t     state;
    state_t     next_state;
    logic [5:0] pix_count;
    logic       draw_state;
    logic       last_pixel;

    assign draw_state = (state == DRAW) || (state == FLASH_DRAW) || (state == RESTORE_DRAW);
    assign last_pixel = (pix_count == 6'd63);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state     <= IDLE;
            pix_count <= 6'd0;
        end else begin
            state     <= next_state;
            pix_count <= draw_state ? pix_count + 6'd1 : 6'd0;
        end
    end

`ifdef GRAPHICS_FLASH_EN
    localparam logic [23:0] HOLD_LOAD = 24'(HOLD_CYCLES - 1);

    logic        flash_flag;
    logic [23:0] hold_count;

    // The hold counter is preloaded outside HOLD so it reads HOLD_CYCLES-1 on entry.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            flash_flag <= 1'b0;
            hold_count <= 24'd0;
        end else begin
            if (state == IDLE && go)
                flash_flag <= flash_req;
            if (state == HOLD)
                hold_count <= hold_count - 24'd1;
            else
                hold_count <= HOLD_LOAD;
        end
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{flash_req, HOLD_CYCLES[0]};
`endif

    always_comb begin
        next_state = state;
        case (state)
            IDLE:  if (go) next_state = LOAD;
            LOAD:  next_state = DRAW;
`ifdef GRAPHICS_FLASH_EN
            DRAW:         if (last_pixel) next_state = flash_flag ? FLASH_SET : DONE;
            FLASH_SET:    next_state = FLASH_DRAW;
            FLASH_DRAW:   if (last_pixel) next_state = HOLD;
            HOLD:         if (hold_count == 24'd0) next_state = RESTORE;
            RESTORE:      next_state = RESTORE_DRAW;
            RESTORE_DRAW: if (last_pixel) next_state = DONE;
`else
            DRAW:         if (last_pixel) next_state = DONE;
`endif
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        load        = 1'b0;
        enable      = 1'b0;
        flash       = 1'b0;
        ld_previous = 1'b0;
        plot        = 1'b0;
        done        = 1'b0;
        busy        = (state != IDLE);
        case (state)
            LOAD: begin
                load   = 1'b1;
                enable = 1'b1;
            end
            DRAW, FLASH_DRAW, RESTORE_DRAW: begin
                enable = 1'b1;
                plot   = 1'b1;
            end
`ifdef GRAPHICS_FLASH_EN
            FLASH_SET: flash       = 1'b1;
            RESTORE:   ld_previous = 1'b1;
`endif
            DONE:      done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_graphics_control.sv
// Directed bench for graphics_control with HOLD_CYCLES=4; the flash sequence is
// exercised when GRAPHICS_FLASH_EN is defined, otherwise flash_req must be ignored.
module tb_graphics_control;

    logic clock = 1'b0;
    logic resetn;
    logic go;
    logic flash_req;
    logic load, enable, flash, ld_previous, plot, busy, done;
    logic [6:0] outs;

    int assertCount = 0;
    int failCount   = 0;

    // Output vector order: {load, enable, flash, ld_previous, plot, busy, done}
    localparam logic [6:0] V_IDLE = 7'b0000000;
    localparam logic [6:0] V_LOAD = 7'b1100010;
    localparam logic [6:0] V_DRAW = 7'b0100110;
    localparam logic [6:0] V_FSET = 7'b0010010;
    localparam logic [6:0] V_HOLD = 7'b0000010;
    localparam logic [6:0] V_REST = 7'b0001010;
    localparam logic [6:0] V_DONE = 7'b0000011;

    assign outs = {load, enable, flash, ld_previous, plot, busy, done};

    always #5 clock = ~clock;

    graphics_control #(.HOLD_CYCLES(4)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .go          (go),
        .flash_req   (flash_req),
        .load        (load),
        .enable      (enable),
        .flash       (flash),
        .ld_previous (ld_previous),
        .plot        (plot),
        .busy        (busy),
        .done        (done)
    );

    task automatic checkOutput(input string tag, input logic [6:0] actual, input logic [6:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %b, expected %b", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic goValue, input logic flashValue);
        go        = goValue;
        flash_req = flashValue;
    endtask

    task automatic nextCycle();
        @(posedge clock);
        #1;
    endtask

    // Cycle c is the period after edge c-1, with go sampled at edge 0.
    function automatic logic [6:0] expectedVec(input int cyc, input bit flashPath);
        if (cyc == 1) return V_LOAD;
        if (!flashPath) begin
            if (cyc <= 65) return V_DRAW;
            if (cyc == 66) return V_DONE;
            return V_IDLE;
        end
        if (cyc <= 65)  return V_DRAW;
        if (cyc == 66)  return V_FSET;
        if (cyc <= 130) return V_DRAW;
        if (cyc <= 134) return V_HOLD;
        if (cyc == 135) return V_REST;
        if (cyc <= 199) return V_DRAW;
        if (cyc == 200) return V_DONE;
        return V_IDLE;
    endfunction

    task automatic runSequence(input string name, input logic withFlash, input bit expectFlash, input int lastCycle);
        applyStimulus(1'b1, withFlash);
        for (int cyc = 1; cyc <= lastCycle; cyc++) begin
            nextCycle();
            if (cyc == 1) applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("%s c%0d", name, cyc), outs, expectedVec(cyc, expectFlash));
        end
    endtask

    initial begin
        int plotCount;
        int doneCount;

        resetn = 1'b0;
        applyStimulus(1'b0, 1'b0);
        nextCycle();
        nextCycle();
        checkOutput("reset", outs, V_IDLE);
        resetn = 1'b1;
        nextCycle();
        checkOutput("idle after reset", outs, V_IDLE);

        runSequence("basic", 1'b0, 1'b0, 67);

`ifdef GRAPHICS_FLASH_EN
        runSequence("flash", 1'b1, 1'b1, 201);
`else
        runSequence("flash ignored", 1'b1, 1'b0, 67);
`endif

        // A second go mid-draw must neither restart nor queue a sequence.
        plotCount = 0;
        doneCount = 0;
        applyStimulus(1'b1, 1'b0);
        for (int cyc = 1; cyc <= 80; cyc++) begin
            nextCycle();
            if (cyc == 1)  applyStimulus(1'b0, 1'b0);
            if (cyc == 30) applyStimulus(1'b1, 1'b1);
            if (cyc == 31) applyStimulus(1'b0, 1'b0);
            if (plot) plotCount++;
            if (done) doneCount++;
            checkOutput($sformatf("go mid-draw c%0d", cyc), outs, expectedVec(cyc, 1'b0));
        end
        checkOutput("go mid-draw plot count", 7'(plotCount), 7'd64);
        checkOutput("go mid-draw done count", 7'(doneCount), 7'd1);

        // Reset during DRAW aborts without a done pulse.
        applyStimulus(1'b1, 1'b0);
        for (int cyc = 1; cyc <= 40; cyc++) begin
            nextCycle();
            if (cyc == 1) applyStimulus(1'b0, 1'b0);
            checkOutput($sformatf("pre-abort c%0d", cyc), outs, expectedVec(cyc, 1'b0));
        end
        resetn = 1'b0;
        nextCycle();
        checkOutput("abort outputs", outs, V_IDLE);
        resetn = 1'b1;
        doneCount = 0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            nextCycle();
            if (done) doneCount++;
        end
        checkOutput("abort no done", 7'(doneCount), 7'd0);
        checkOutput("abort idle", outs, V_IDLE);
        runSequence("after abort", 1'b0, 1'b0, 67);

        // go held high: a new sequence starts every 67 cycles.
        applyStimulus(1'b1, 1'b0);
        for (int cyc = 1; cyc <= 201; cyc++) begin
            nextCycle();
            checkOutput($sformatf("go held c%0d", cyc), outs, expectedVec(((cyc - 1) % 67) + 1, 1'b0));
            if (cyc == 200) applyStimulus(1'b0, 1'b0);
        end
        nextCycle();
        checkOutput("go released idle", outs, V_IDLE);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/graphics_control.md
GRAPHICS_CONTROL -- requirements
Module: graphics_control

Interface
REQ-001 The block SHALL have parameter HOLD_CYCLES, default 12500000, the number of cycles the white flash image is held (legal range 1 to 2^24-1).
REQ-002 The block SHALL have port clock, input, 1 bit: the system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port resetn, input, 1 bit: synchronous, active-low reset.
REQ-004 The block SHALL have port go, input, 1 bit: draw request, sampled only in IDLE.
REQ-005 The block SHALL have port flash_req, input, 1 bit: with go, requests the flash-and-restore sequence after the draw.
REQ-006 The block SHALL have port load, output, 1 bit: datapath loads x/y/colour and clears its pixel counter.
REQ-007 The block SHALL have port enable, output, 1 bit: datapath pixel counter advance/clear enable.
REQ-008 The block SHALL have port flash, output, 1 bit: datapath forces colour to 3'b111.
REQ-009 The block SHALL have port ld_previous, output, 1 bit: datapath restores the last loaded x/y/colour.
REQ-010 The block SHALL have port plot, output, 1 bit: frame-buffer write enable for the current datapath pixel.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle completion pulse.

Function
REQ-013 The block SHALL implement states IDLE, LOAD, DRAW, FLASH_SET, FLASH_DRAW, HOLD, RESTORE, RESTORE_DRAW and DONE, with outputs decoded from state only (Moore).
REQ-014 IDLE SHALL go to LOAD when go=1 and SHALL latch flash_req into an internal flag at that edge; otherwise IDLE SHALL remain in IDLE.
REQ-015 LOAD SHALL last one cycle with load=1 and enable=1, so the datapath counter is cleared to 0.
REQ-016 DRAW, FLASH_DRAW and RESTORE_DRAW SHALL each last exactly 64 cycles with enable=1 and plot=1, tracked by an internal 6-bit counter that is 0 on entry and exits on count 63.
REQ-017 After DRAW, the block SHALL go to FLASH_SET if the latched flag is 1, otherwise to DONE.
REQ-018 FLASH_SET SHALL last one cycle with flash=1 and enable=0, then go to FLASH_DRAW.
REQ-019 HOLD SHALL last exactly HOLD_CYCLES cycles with all datapath controls at 0, tracked by a 24-bit down-counter, then go to RESTORE.
REQ-020 RESTORE SHALL last one cycle with ld_previous=1 and enable=0, then go to RESTORE_DRAW.
REQ-021 RESTORE_DRAW SHALL go to DONE; DONE SHALL last one cycle with done=1, then go to IDLE.
REQ-022 enable SHALL be 0 outside LOAD and the three draw states, so the datapath counter is 0 at the start of every draw (64-count wrap).
REQ-023 load, flash and ld_previous SHALL never be asserted in the same cycle.
REQ-024 go and flash_req SHALL be ignored while busy=1, with no queuing.
REQ-025 Latency from go sampled at edge N SHALL be: load in cycle N+1, first plot in cycle N+2, done in cycle N+66 without flash and N+196+HOLD_CYCLES with flash.
REQ-026 go held high across DONE SHALL start a new sequence directly from the following IDLE cycle.

Reset
REQ-027 When resetn=0 at a clock edge, the block SHALL enter IDLE and clear the latched flag, the pixel counter and the hold counter, so that load, enable, flash, ld_previous, plot, busy and done are all 0 in the next cycle.
REQ-028 A reset asserted mid-sequence SHALL abort the sequence without producing a done pulse.

Configuration
REQ-029 With macro GRAPHICS_FLASH_EN defined, the block SHALL include the FLASH_SET, FLASH_DRAW, HOLD and RESTORE_DRAW path and the RESTORE state, as specified above.
REQ-030 Without GRAPHICS_FLASH_EN, the flash path and hold counter SHALL be absent, flash_req SHALL be ignored, flash and ld_previous SHALL be tied to 0, and DRAW SHALL always go to DONE.

Verification (HOLD_CYCLES=4)
REQ-031 The bench SHALL cover: reset, then go=1 for one cycle with flash_req=0 -> load in cycle 1; plot=1 for exactly cycles 2-65; done=1 in cycle 66 only; busy=0 in cycle 67.
REQ-032 The bench SHALL cover: GRAPHICS_FLASH_EN defined, go=1 with flash_req=1 -> flash=1 in cycle 66; plot in cycles 67-130; all controls 0 in cycles 131-134; ld_previous=1 in cycle 135; plot in cycles 136-199; done=1 in cycle 200.
REQ-033 The bench SHALL cover: go pulsed again in cycle 30 of a draw -> no restart; exactly 64 plot cycles; a single done.
REQ-034 The bench SHALL cover: resetn=0 in cycle 40 of DRAW -> all outputs 0 in the next cycle; no done pulse; a new go afterwards completes normally.
REQ-035 The bench SHALL cover: go held high continuously without flash -> done pulses every 67 cycles; load follows each IDLE cycle.
REQ-036 The bench SHALL cover: GRAPHICS_FLASH_EN undefined, go=1 with flash_req=1 -> flash and ld_previous stay 0; done in cycle 66.
